m_ext_seq: RTL and testbench

Sequencing controller for the RV32M multiply/divide datapath. It accepts one M-extension operation at a time over a valid/ready handshake and decodes funct3 into the datapath's sign/mix/mult_or_div controls. It holds the operands stable for a configurable multicycle settle window, resolves the RISC-V divide special cases without the datapath, and reuses the last datapath result when a fused pair arrives (MULH→MUL, DIV→REM). It sits between the execute-stage issue logic and the M datapath instance.

---
 rtl/m_ext_seq.sv | 198 +++++++++++++++++++
 tb/tb_m_ext_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_seq.sv
// m_ext_seq: RV32M issue/sequence controller.
// Decodes funct3, times the datapath, handles div corner cases and fused pairs.
module m_ext_seq #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  in_tag,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  out_tag,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic        m_sign,
  output logic        m_mix,
  output logic        m_mult_or_div,
  input  logic [31:0] m_uh,
  input  logic [31:0] m_lh
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [15:0] MUL_LOAD = 16'(MUL_CYCLES - 1);
  localparam logic [15:0] DIV_LOAD = 16'(DIV_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic        sel_uh;

  logic        c_valid;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic [31:0] c_uh;
  logic [31:0] c_lh;
  logic [2:0]  c_key;

  logic        d_sign;
  logic        d_mix;
  logic        d_uh;
  logic        is_div;
  logic        accept;
  logic        sp_zero;
  logic        sp_ovf;
  logic        special;
  logic        hit;
  logic [31:0] sp_res;
  logic [31:0] hit_res;
  logic        busy_end;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign is_div    = funct3[2];
  assign busy_end  = (state == BUSY) & (cnt == 16'd0);

  // funct3 decode into datapath controls and result half
  always_comb begin
    d_sign = 1'b0;
    d_mix  = 1'b0;
    d_uh   = 1'b0;
    unique case (funct3)
      3'b000: d_sign = 1'b1;
      3'b001: begin
        d_sign = 1'b1;
        d_uh   = 1'b1;
      end
      3'b010: begin
        d_sign = 1'b1;
        d_mix  = 1'b1;
        d_uh   = 1'b1;
      end
      3'b011: d_uh = 1'b1;
      3'b100: begin
        d_sign = 1'b1;
        d_uh   = 1'b1;
      end
      3'b101: d_uh = 1'b1;
      3'b110: d_sign = 1'b1;
      3'b111: d_sign = 1'b0;
    endcase
  end

  // divide corner cases and fused-pair lookup
  always_comb begin
    sp_zero = is_div & (rs2 == 32'd0);
    sp_ovf  = is_div & d_sign
            & (rs1 == 32'h8000_0000)
            & (rs2 == 32'hFFFF_FFFF);
    special = sp_zero | sp_ovf;
    if (sp_zero)
      sp_res = d_uh ? 32'hFFFF_FFFF : rs1;
    else
      sp_res = d_uh ? 32'h8000_0000 : 32'd0;
    hit = c_valid & ~flush
        & (rs1 == c_a) & (rs2 == c_b)
        & (c_key == {is_div, d_sign, d_mix});
    hit_res = d_uh ? c_uh : c_lh;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next state; flush beats completion and out_ready
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (special | hit) ? DONE : BUSY;
      end
      BUSY: begin
        if (flush)
          state_nx = IDLE;
        else if (cnt == 16'd0)
          state_nx = DONE;
      end
      DONE: begin
        if (flush || out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand/control latch, settle counter and result word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 16'd0;
      result        <= 32'd0;
      out_tag       <= 5'd0;
      m_a           <= 32'd0;
      m_b           <= 32'd0;
      m_sign        <= 1'b0;
      m_mix         <= 1'b0;
      m_mult_or_div <= 1'b0;
      sel_uh        <= 1'b0;
    end else if (accept) begin
      m_a           <= rs1;
      m_b           <= rs2;
      m_sign        <= d_sign;
      m_mix         <= d_mix;
      m_mult_or_div <= is_div;
      sel_uh        <= d_uh;
      out_tag       <= in_tag;
      if (special)
        result <= sp_res;
      else if (hit)
        result <= hit_res;
      else
        cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (state == BUSY && !flush) begin
      if (cnt == 16'd0)
        result <= sel_uh ? m_uh : m_lh;
      else
        cnt <= cnt - 16'd1;
    end
  end

  // last datapath result, reused by fused pairs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_a     <= 32'd0;
      c_b     <= 32'd0;
      c_uh    <= 32'd0;
      c_lh    <= 32'd0;
      c_key   <= 3'd0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (busy_end) begin
      c_valid <= 1'b1;
      c_a     <= m_a;
      c_b     <= m_b;
      c_uh    <= m_uh;
      c_lh    <= m_lh;
      c_key   <= {m_mult_or_div, m_sign, m_mix};
    end
  end

endmodule

// File: tb/tb_m_ext_seq.sv
// tb_m_ext_seq: directed vector bench for m_ext_seq.
// Behavioural datapath stands in for the M unit.
module tb_m_ext_seq;

  localparam int MULC = 3;
  localparam int DIVC = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sign;
  logic        m_mix;
  logic        m_mult_or_div;
  logic [31:0] m_uh;
  logic [31:0] m_lh;

  int n_cmp = 0;
  int n_bad = 0;

  m_ext_seq #(
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .funct3(funct3),
    .rs1(rs1),
    .rs2(rs2),
    .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .out_tag(out_tag),
    .m_a(m_a),
    .m_b(m_b),
    .m_sign(m_sign),
    .m_mix(m_mix),
    .m_mult_or_div(m_mult_or_div),
    .m_uh(m_uh),
    .m_lh(m_lh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: signed/mixed multiply, divide
  always_comb begin
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    logic signed [63:0] pr;
    xa = m_sign ? 64'($signed(m_a)) : {32'd0, m_a};
    xb = (m_sign && !m_mix) ? 64'($signed(m_b))
                            : {32'd0, m_b};
    m_uh = 32'd0;
    m_lh = 32'd0;
    if (!m_mult_or_div) begin
      pr   = xa * xb;
      m_uh = pr[63:32];
      m_lh = pr[31:0];
    end else if (m_b == 32'd0) begin
      m_uh = 32'hFFFF_FFFF;
      m_lh = m_a;
    end else begin
      pr   = xa / xb;
      m_uh = pr[31:0];
      pr   = xa % xb;
      m_lh = pr[31:0];
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int lat,
                       input string nm);
    int n;
    chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    funct3   = f3;
    rs1      = a;
    rs2      = b;
    in_tag   = tag;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " out_tag"}, {27'd0, out_tag}, {27'd0, tag});
    chk({nm, " m_a held"}, m_a, a);
    chk({nm, " m_b held"}, m_b, b);
  endtask

  task automatic ack(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, " idle out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,
                 32'h4000_0000, MULC};
    vecs[1]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 5'd2,
                 32'h0000_0000, 1};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
                 32'hFFFF_FFFE, MULC};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
                 32'hFFFF_FFFF, MULC};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5,
                 32'hFFFF_FFFD, DIVC};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6,
                 32'hFFFF_FFFF, 1};
    vecs[6]  = '{3'b101, 32'd5, 32'd0, 5'd7,
                 32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'b110, 32'd5, 32'd0, 5'd8,
                 32'd5, 1};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
                 32'h8000_0000, 1};
    vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
                 32'd0, 1};
    vecs[10] = '{3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11,
                 32'hFFFF_FFFF, 1};
    vecs[11] = '{3'b000, 32'd3, 32'd5, 5'd12,
                 32'd15, MULC};
    vecs[12] = '{3'b101, 32'd100, 32'd7, 5'd13,
                 32'd14, DIVC};
    vecs[13] = '{3'b111, 32'd100, 32'd7, 5'd14,
                 32'd2, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    funct3    = 3'd0;
    rs1       = 32'd0;
    rs2       = 32'd0;
    in_tag    = 5'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst m_a", m_a, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag,
            vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      ack($sformatf("vec%0d", i));
    end

    // backpressure: hold DONE for 10 cycles
    do_op(3'b100, 32'd20, 32'd3, 5'd20, 32'd6, DIVC, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp result", result, 32'd6);
      chk("bp out_tag", {27'd0, out_tag}, 32'd20);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
    end
    ack("bp");

    // flush mid-BUSY, then the cached pair must miss
    funct3   = 3'b100;
    rs1      = 32'hFFFF_FFF9;
    rs2      = 32'd2;
    in_tag   = 5'd21;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("fl busy out_valid", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("fl out_valid", {31'd0, out_valid}, 32'd0);
    end
    do_op(3'b110, 32'd20, 32'd3, 5'd22, 32'd2, DIVC, "fl rem");
    ack("fl rem");

    // async reset pulse mid-BUSY
    funct3   = 3'b100;
    rs1      = 32'd1000;
    rs2      = 32'd10;
    in_tag   = 5'd23;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar result", result, 32'd0);
    chk("ar out_tag", {27'd0, out_tag}, 32'd0);
    chk("ar m_a", m_a, 32'd0);
    chk("ar m_b", m_b, 32'd0);
    chk("ar ctrl", {29'd0, m_sign, m_mix, m_mult_or_div}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(3'b110, 32'd20, 32'd3, 5'd24, 32'd2, DIVC, "ar rem");
    ack("ar rem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
